// File: rtl/pwm_pkg.sv
// Shared types for the PWM power-stage blocks.
// Gate-drive FSM states and default dead-time counter width.
package pwm_pkg;

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        DEAD  = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        FAULT = 3'd4
    } dt_state_e;

    localparam int DT_WIDTH_DEF = 8;

endpackage

// File: rtl/dt_counter.sv
// Loadable down-counter timing the both-low gap of the gate driver.
// Decrement saturates at zero so the loaded value is the only source of count.
module dt_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dead_time_gen.sv
// Complementary high/low gate-drive pair with programmable dead time,
// enable gating and a sticky fault shutdown.
module dead_time_gen
    import pwm_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEF
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic                fault_i,
    input  logic                pwm_i,
    input  logic [DT_WIDTH-1:0] dead_time_i,
    output logic                hs_o,
    output logic                ls_o,
    output logic                dt_active_o,
    output logic                fault_o
);

    dt_state_e state_q;
    dt_state_e state_d;
    logic      hs_q;
    logic      ls_q;
    logic      dt_q;
    logic      fault_q;
    logic      cnt_load;
    logic      cnt_dec;
    logic      cnt_zero;

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        if (fault_i) begin
            state_d = FAULT;
        end else if (state_q == FAULT) begin
            state_d = enable_i ? FAULT : OFF;
        end else if (!enable_i) begin
            state_d = OFF;
        end else begin
            unique case (state_q)
                OFF: begin
                    state_d  = DEAD;
                    cnt_load = 1'b1;
                end
                DEAD: begin
                    if (cnt_zero) begin
                        state_d = pwm_i ? HIGH : LOW;
                    end
                end
                HIGH: begin
                    if (!pwm_i) begin
                        state_d  = DEAD;
                        cnt_load = 1'b1;
                    end
                end
                LOW: begin
                    if (pwm_i) begin
                        state_d  = DEAD;
                        cnt_load = 1'b1;
                    end
                end
                default: begin
                    state_d = OFF;
                end
            endcase
        end
    end

    // Count down only while the gap is still running.
    assign cnt_dec = (state_q == DEAD) && (state_d == DEAD) && !cnt_zero;

    dt_counter #(
        .W(DT_WIDTH)
    ) u_cnt (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .load_i    (cnt_load),
        .load_val_i(dead_time_i),
        .dec_i     (cnt_dec),
        .zero_o    (cnt_zero)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= OFF;
            hs_q    <= 1'b0;
            ls_q    <= 1'b0;
            dt_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hs_q    <= (state_d == HIGH);
            ls_q    <= (state_d == LOW);
            dt_q    <= (state_d == DEAD);
            fault_q <= (state_d == FAULT);
        end
    end

    assign hs_o        = hs_q;
    assign ls_o        = ls_q;
    assign dt_active_o = dt_q;
    assign fault_o     = fault_q;

endmodule
